reshape_scheduler: RTL and testbench

RESHAPE_SCHEDULER -- requirements
Module: reshape_scheduler

---
 rtl/reshape_pkg.sv | 14 +
 rtl/rs_addr_xlate.sv | 15 +
 rtl/reshape_scheduler.sv | 160 ++++++++++++++++
 tb/tb_reshape_scheduler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reshape_pkg.sv
// Shared constants and FSM state type for the reshape frame scheduler.
package reshape_pkg;
    localparam int ADDR_W       = 20;
    localparam int FRAME_PIXELS = 76800;
    localparam int BANK_BASE    = FRAME_PIXELS;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_RUN,
        ST_DONE,
        ST_ERR
    } state_e;
endpackage

// File: rtl/rs_addr_xlate.sv
// Frame-relative to absolute RAM address: adds the bank base when bank 1 is selected.
module rs_addr_xlate #(
    parameter int ADDR_W = reshape_pkg::ADDR_W,
    parameter int BASE   = reshape_pkg::BANK_BASE
) (
    input  logic              bank,
    input  logic [ADDR_W-1:0] addr_in,
    output logic [ADDR_W-1:0] addr_out
);
    localparam logic [ADDR_W-1:0] BASE_L = ADDR_W'(BASE);

    always_comb begin
        addr_out = addr_in + (bank ? BASE_L : '0);
    end
endmodule

// File: rtl/reshape_scheduler.sv
// Hands capture frames to FlowReshaper, ping-pongs destination banks,
// translates reshaper addresses and polices strobes outside an active frame.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | waiting for a source frame, frm_ready high
//   ST_START | one-cycle rs_ena pulse, counters loaded
//   ST_RUN   | reshaper owns the RAM ports, counting writes and cycles
//   ST_DONE  | one-cycle done pulse, destination bank flips on exit
//   ST_ERR   | timed out, held until err_clr
module reshape_scheduler #(
    parameter int ADDR_W       = reshape_pkg::ADDR_W,
    parameter int FRAME_PIXELS = reshape_pkg::FRAME_PIXELS,
    parameter int TIMEOUT_CYC  = 400000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              frm_valid,
    input  logic              frm_bank,
    output logic              frm_ready,
    output logic              rs_ena,
    input  logic              rs_rd_en,
    input  logic [ADDR_W-1:0] rs_rd_addr,
    input  logic              rs_wr_en,
    input  logic [ADDR_W-1:0] rs_wr_addr,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic              busy,
    output logic              done,
    output logic              done_bank,
    output logic [15:0]       frame_cnt,
    output logic              err_timeout,
    output logic              err_spur,
    input  logic              err_clr
);
    import reshape_pkg::*;

    localparam int            TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [16:0]   WR_LAST = 17'(FRAME_PIXELS - 1);

    state_e          state_q, state_d;
    logic            src_bank_q, src_bank_d;
    logic            dst_bank_q, dst_bank_d;
    logic [16:0]     wr_cnt_q, wr_cnt_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;
    logic            err_timeout_q, err_timeout_d;
    logic            err_spur_q, err_spur_d;
    logic            in_run;
    logic            last_wr;

    assign in_run  = (state_q == ST_RUN);
    assign last_wr = rs_wr_en && (wr_cnt_q == WR_LAST);

    always_comb begin
        state_d       = state_q;
        src_bank_d    = src_bank_q;
        dst_bank_d    = dst_bank_q;
        wr_cnt_d      = wr_cnt_q;
        to_cnt_d      = to_cnt_q;
        frame_cnt_d   = frame_cnt_q;
        err_timeout_d = err_timeout_q;
        err_spur_d    = err_spur_q;

        if (err_clr) begin
            err_timeout_d = 1'b0;
            err_spur_d    = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (frm_valid) begin
                    src_bank_d = frm_bank;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                wr_cnt_d = '0;
                to_cnt_d = TO_LOAD;
                state_d  = ST_RUN;
            end
            ST_RUN: begin
                if (to_cnt_q != '0) to_cnt_d = to_cnt_q - TO_W'(1);
                if (rs_wr_en) wr_cnt_d = wr_cnt_q + 17'd1;
                // The final write wins over a timeout landing in the same cycle.
                if (last_wr) begin
                    state_d     = ST_DONE;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end else if (to_cnt_q == '0) begin
                    state_d       = ST_ERR;
                    err_timeout_d = 1'b1;
                end
            end
            ST_DONE: begin
                dst_bank_d = ~dst_bank_q;
                state_d    = ST_IDLE;
            end
            ST_ERR: begin
                if (err_clr) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (!in_run && (rs_rd_en || rs_wr_en)) err_spur_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= ST_IDLE;
            src_bank_q    <= 1'b0;
            dst_bank_q    <= 1'b0;
            wr_cnt_q      <= '0;
            to_cnt_q      <= '0;
            frame_cnt_q   <= '0;
            err_timeout_q <= 1'b0;
            err_spur_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            src_bank_q    <= src_bank_d;
            dst_bank_q    <= dst_bank_d;
            wr_cnt_q      <= wr_cnt_d;
            to_cnt_q      <= to_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            err_timeout_q <= err_timeout_d;
            err_spur_q    <= err_spur_d;
        end
    end

    rs_addr_xlate #(
        .ADDR_W (ADDR_W),
        .BASE   (FRAME_PIXELS)
    ) u_rd_xlate (
        .bank     (src_bank_q),
        .addr_in  (rs_rd_addr),
        .addr_out (mem_rd_addr)
    );

    rs_addr_xlate #(
        .ADDR_W (ADDR_W),
        .BASE   (FRAME_PIXELS)
    ) u_wr_xlate (
        .bank     (dst_bank_q),
        .addr_in  (rs_wr_addr),
        .addr_out (mem_wr_addr)
    );

    assign frm_ready   = (state_q == ST_IDLE);
    assign rs_ena      = (state_q == ST_START);
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign done_bank   = done && dst_bank_q;
    assign mem_rd_en   = in_run && rs_rd_en;
    assign mem_wr_en   = in_run && rs_wr_en;
    assign frame_cnt   = frame_cnt_q;
    assign err_timeout = err_timeout_q;
    assign err_spur    = err_spur_q;
endmodule

// File: tb/tb_reshape_scheduler.sv
// Directed frame scenarios with randomized reshaper traffic, checked against a
// frame-level model of banks, counts and error flags.
module tb_reshape_scheduler;
    localparam int ADDR_W = 20;
    localparam int FP     = 64;
    localparam int TO     = 1000;

    logic              clk = 1'b0;
    logic              rstn;
    logic              frm_valid;
    logic              frm_bank;
    logic              frm_ready;
    logic              rs_ena;
    logic              rs_rd_en;
    logic [ADDR_W-1:0] rs_rd_addr;
    logic              rs_wr_en;
    logic [ADDR_W-1:0] rs_wr_addr;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic              busy;
    logic              done;
    logic              done_bank;
    logic [15:0]       frame_cnt;
    logic              err_timeout;
    logic              err_spur;
    logic              err_clr;

    int checks = 0;
    int errors = 0;

    logic        m_src;
    logic        m_dst;
    logic [15:0] m_cnt;

    always #5 clk = ~clk;

    reshape_scheduler #(
        .ADDR_W       (ADDR_W),
        .FRAME_PIXELS (FP),
        .TIMEOUT_CYC  (TO)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .frm_valid   (frm_valid),
        .frm_bank    (frm_bank),
        .frm_ready   (frm_ready),
        .rs_ena      (rs_ena),
        .rs_rd_en    (rs_rd_en),
        .rs_rd_addr  (rs_rd_addr),
        .rs_wr_en    (rs_wr_en),
        .rs_wr_addr  (rs_wr_addr),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .busy        (busy),
        .done        (done),
        .done_bank   (done_bank),
        .frame_cnt   (frame_cnt),
        .err_timeout (err_timeout),
        .err_spur    (err_spur),
        .err_clr     (err_clr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ADDR_W-1:0] bank_addr(input logic bank, input logic [ADDR_W-1:0] a);
        return bank ? a + ADDR_W'(FP) : a;
    endfunction

    task automatic chk_reset_values(input string tag);
        chk(tag, 64'({frm_ready, rs_ena, done, done_bank, busy, err_timeout, err_spur,
                      mem_rd_en, mem_wr_en}), 64'(9'b1_0000_0000));
        chk({tag, "_cnt"}, 64'(frame_cnt), 64'(16'h0000));
    endtask

    task automatic start_frame(input logic bank, input logic keep);
        @(negedge clk);
        frm_valid = 1'b1;
        frm_bank  = bank;
        #1;
        chk("accept_ready", 64'({frm_ready, busy}), 64'(2'b10));
        m_src = bank;
        @(negedge clk);
        frm_valid = keep;
        #1;
        chk("start_pulse", 64'({rs_ena, busy, frm_ready, mem_rd_en, mem_wr_en}), 64'(5'b11000));
    endtask

    // Drives reshaper traffic until a full frame is written, stop_wr writes are
    // seen, or TO run cycles elapse; writes cease after stall_after.
    task automatic run_phase(input int stop_wr, input int stall_after, output int wr, output int rc);
        bit fin;
        fin = 1'b0;
        wr  = 0;
        rc  = 0;
        while (!fin) begin
            @(negedge clk);
            rs_wr_en   = (wr < stall_after) && ($urandom_range(0, 3) != 0);
            rs_wr_addr = ADDR_W'($urandom_range(0, FP - 1));
            rs_rd_en   = ($urandom_range(0, 1) == 1) || (rc == TO - 1);
            rs_rd_addr = ADDR_W'($urandom_range(0, FP - 1));
            #1;
            chk("run_rd", 64'({mem_rd_en, mem_rd_addr}), 64'({rs_rd_en, bank_addr(m_src, rs_rd_addr)}));
            chk("run_wr", 64'({mem_wr_en, mem_wr_addr}), 64'({rs_wr_en, bank_addr(m_dst, rs_wr_addr)}));
            chk("run_status", 64'({busy, rs_ena, done, err_timeout, frm_ready}), 64'(5'b10000));
            if (rs_wr_en) wr++;
            rc++;
            if (wr == FP || wr == stop_wr || rc == TO) fin = 1'b1;
        end
    endtask

    task automatic finish_done(input logic keep, input logic next_bank);
        @(negedge clk);
        rs_rd_en  = 1'b0;
        rs_wr_en  = 1'b0;
        frm_valid = keep;
        frm_bank  = next_bank;
        #1;
        chk("done_pulse", 64'({done, done_bank, busy, frm_ready, rs_ena}),
            64'({1'b1, m_dst, 1'b1, 1'b0, 1'b0}));
        m_dst = ~m_dst;
        m_cnt = m_cnt + 16'd1;
        @(negedge clk);
        #1;
        chk("after_done", 64'({done, busy, frm_ready, err_timeout, err_spur}), 64'(5'b00100));
        chk("frame_cnt", 64'(frame_cnt), 64'(m_cnt));
    endtask

    task automatic full_frame(input logic bank);
        int wr, rc;
        start_frame(bank, 1'b0);
        run_phase(FP, FP, wr, rc);
        finish_done(1'b0, 1'b0);
    endtask

    initial begin
        int wr, rc;
        logic b;

        rstn       = 1'b0;
        frm_valid  = 1'b1;
        frm_bank   = 1'b1;
        rs_rd_en   = 1'b1;
        rs_rd_addr = '0;
        rs_wr_en   = 1'b1;
        rs_wr_addr = '0;
        err_clr    = 1'b0;
        m_src      = 1'b0;
        m_dst      = 1'b0;
        m_cnt      = 16'h0000;

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk_reset_values("reset");
        @(negedge clk);
        rstn      = 1'b1;
        frm_valid = 1'b0;
        rs_rd_en  = 1'b0;
        rs_wr_en  = 1'b0;

        // Spurious write in IDLE
        @(negedge clk);
        rs_wr_en   = 1'b1;
        rs_wr_addr = ADDR_W'(5);
        #1;
        chk("spur_block", 64'({mem_wr_en, busy}), 64'(2'b00));
        @(negedge clk);
        rs_wr_en = 1'b0;
        #1;
        chk("spur_flag", 64'({err_spur, busy, frm_ready}), 64'(3'b101));
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        chk("spur_clr", 64'({err_spur, frm_ready}), 64'(2'b01));

        // Timeout: reshaper stalls after 10 writes
        start_frame(1'b1, 1'b0);
        run_phase(FP, 10, wr, rc);
        @(negedge clk);
        rs_rd_en = 1'b1;
        rs_wr_en = 1'b1;
        #1;
        chk("to_err", 64'({err_timeout, busy, frm_ready, mem_rd_en, mem_wr_en, rs_ena, done}),
            64'(7'b1100000));
        @(negedge clk);
        rs_rd_en = 1'b0;
        rs_wr_en = 1'b0;
        err_clr  = 1'b1;
        #1;
        chk("to_err_hold", 64'({busy, err_timeout, err_spur}), 64'(3'b111));
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        chk("to_clr", 64'({busy, frm_ready, err_timeout, err_spur}), 64'(4'b0100));
        chk("to_frame_cnt", 64'(frame_cnt), 64'(m_cnt));

        // Single frame from source bank 1
        full_frame(1'b1);

        // Reset in the middle of a frame
        start_frame(1'($urandom_range(0, 1)), 1'b0);
        run_phase(30, FP, wr, rc);
        @(negedge clk);
        rstn     = 1'b0;
        rs_rd_en = 1'b1;
        rs_wr_en = 1'b1;
        @(negedge clk);
        #1;
        chk_reset_values("rst_run");
        @(negedge clk);
        rstn     = 1'b1;
        rs_rd_en = 1'b0;
        rs_wr_en = 1'b0;
        m_src    = 1'b0;
        m_dst    = 1'b0;
        m_cnt    = 16'h0000;

        // Back-to-back frames with frm_valid held high
        start_frame(1'b0, 1'b1);
        run_phase(FP, FP, wr, rc);
        finish_done(1'b1, 1'b1);
        @(negedge clk);
        frm_valid = 1'b0;
        m_src     = 1'b1;
        #1;
        chk("b2b_start", 64'({rs_ena, busy, frm_ready}), 64'(3'b110));
        run_phase(FP, FP, wr, rc);
        finish_done(1'b0, 1'b0);

        // frame_cnt wrap
        @(negedge clk);
        force dut.frame_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt_q;
        m_cnt = 16'hFFFF;
        #1;
        chk("wrap_preload", 64'(frame_cnt), 64'(m_cnt));
        full_frame(1'($urandom_range(0, 1)));
        chk("wrap_zero", 64'(frame_cnt), 64'(16'h0000));

        // Random-bank frames
        for (int i = 0; i < 4; i++) begin
            b = 1'($urandom_range(0, 1));
            full_frame(b);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
